// File: rtl/axis_out_fifo.sv
// Output-side AXI-Stream FIFO behind the FIR engine. It buffers results and
// tracks frame boundaries: it counts delivered samples and flags frames whose length is wrong.
module axis_out_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  input  logic [31:0]            data_length,
  input  logic                   clr,
  output logic [4:0]             level,
  output logic [31:0]            out_count,
  output logic                   frame_done,
  output logic                   len_err
);

  // state  | meaning
  // IDLE   | no sample of the current frame delivered yet, out_count=0
  // STREAM | frame in progress, waiting for the tlast sample
  // DONE   | tlast sample just delivered, frame_done pulses this cycle
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam int         PW   = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam logic [4:0] FULL = 5'(pDEPTH);

  logic [pDATA_WIDTH:0] mem [pDEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [4:0]           level_q;
  state_t               state;
  logic                 push;
  logic                 pop;
  logic                 flush;
  logic [31:0]          cnt_next;
  logic                 len_bad;

  assign flush    = ~axis_rst_n | clr;
  assign s_tready = (level_q != FULL);
  assign m_tvalid = (level_q != 5'd0);
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign level    = level_q;

  // Head entry falls through directly; it is forced to zero while the FIFO is empty.
  assign {m_tlast, m_tdata} = m_tvalid ? mem[rd_ptr] : '0;

  // A pop in DONE already belongs to the next frame, so it counts from zero.
  always_comb begin
    cnt_next = 32'd1;
    len_bad  = 1'b0;
    if (state != DONE)
      cnt_next = out_count + 32'd1;
    if (m_tlast)
      len_bad = (cnt_next != data_length);
    else
      len_bad = (cnt_next >= data_length);
  end

  always_ff @(posedge axis_clk) begin
    if (push && !flush)
      mem[wr_ptr] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge axis_clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= 5'd0;
      state      <= IDLE;
      out_count  <= 32'd0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        level_q <= level_q + 5'd1;
      else if (pop && !push)
        level_q <= level_q - 5'd1;

      frame_done <= 1'b0;
      if (pop) begin
        out_count <= cnt_next;
        if (len_bad)
          len_err <= 1'b1;
        if (m_tlast) begin
          state      <= DONE;
          frame_done <= 1'b1;
        end else begin
          state <= STREAM;
        end
      end else if (state == DONE) begin
        state     <= IDLE;
        out_count <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_axis_out_fifo.sv
// Bench for axis_out_fifo: queue scoreboard on the data path plus directed
// checks of the frame counter, frame_done and len_err.
module tb_axis_out_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic          m_tready = 1'b0;
  logic [31:0]   data_length = 32'd3;
  logic          clr = 1'b0;
  logic [4:0]    level;
  logic [31:0]   out_count;
  logic          frame_done;
  logic          len_err;

  int checks = 0;
  int failures = 0;
  int mdl_level = 0;
  int fd_cnt = 0;
  int fd0;
  logic wrap_run;
  logic [DW:0] sb [$];
  logic [DW:0] exp_word;

  axis_out_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .data_length(data_length), .clr(clr), .level(level), .out_count(out_count),
    .frame_done(frame_done), .len_err(len_err)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l);
    int n = 0;
    logic acc;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    do begin
      @(negedge axis_clk);
      acc = s_tready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    m_tready = 1'b1;
    while (level != 5'd0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_level", 64'(level), 64'd0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Reference model: occupancy counter plus ordered queue of {last,data}.
  always @(negedge axis_clk) begin
    logic do_push, do_pop;
    chk("level", 64'(level), 64'(mdl_level));
    chk("s_tready", 64'(s_tready), 64'(mdl_level != DEPTH));
    chk("m_tvalid", 64'(m_tvalid), 64'(mdl_level != 0));
    if (mdl_level == 0) chk("empty_head", 64'({m_tlast, m_tdata}), 64'd0);
    if (!axis_rst_n || clr) begin
      sb.delete();
      mdl_level = 0;
    end else begin
      do_pop  = (mdl_level != 0) && m_tready;
      do_push = s_tvalid && (mdl_level != DEPTH);
      if (do_pop) begin
        if (sb.size() == 0) chk("sb_underflow", 64'd0, 64'd1);
        else begin
          exp_word = sb.pop_front();
          chk("data", 64'({m_tlast, m_tdata}), 64'(exp_word));
        end
      end
      if (do_push) sb.push_back({s_tlast, s_tdata});
      mdl_level = mdl_level + int'(do_push) - int'(do_pop);
    end
    if (frame_done) fd_cnt++;
  end

  initial begin
    // reset values
    tick();
    tick();
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    axis_rst_n = 1'b1;
    tick();

    // basic frame of 3, one-cycle latency
    data_length = 32'd3;
    m_tready = 1'b1;
    fd0 = fd_cnt;
    push(32'd10, 1'b0);
    chk("lat_10", 64'(m_tdata), 64'd10);
    push(32'd20, 1'b0);
    chk("lat_20", 64'(m_tdata), 64'd20);
    push(32'd30, 1'b1);
    chk("lat_30", 64'({m_tlast, m_tdata}), 64'({1'b1, 32'd30}));
    tick();
    chk("fd_pulse", 64'(frame_done), 64'd1);
    chk("fd_count3", 64'(out_count), 64'd3);
    tick();
    chk("fd_end", 64'(frame_done), 64'd0);
    chk("idle_count", 64'(out_count), 64'd0);
    tick();
    chk("fd_once", 64'(fd_cnt - fd0), 64'd1);
    chk("len_ok", 64'(len_err), 64'd0);

    // fill to full, hold the 9th upstream, then pop while full
    do_clr();
    data_length = 32'd100;
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'(100 + i), 1'b0);
    chk("full_level", 64'(level), 64'd8);
    chk("full_ready", 64'(s_tready), 64'd0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd108;
    tick();
    tick();
    chk("full_hold", 64'(level), 64'd8);
    m_tready = 1'b1;
    tick();
    chk("full_pop_nopush", 64'(level), 64'd7);
    tick();
    chk("push_pop_level", 64'(level), 64'd7);
    s_tvalid = 1'b0;
    drain();

    // short frame: tlast at 3 with length 4
    do_clr();
    data_length = 32'd4;
    m_tready = 1'b1;
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b1);
    tick();
    chk("len_short", 64'(len_err), 64'd1);
    do_clr();
    chk("clr_len_err", 64'(len_err), 64'd0);
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_out_count", 64'(out_count), 64'd0);

    // long frame: no tlast at sample 4
    push(32'd11, 1'b0);
    push(32'd12, 1'b0);
    push(32'd13, 1'b0);
    tick();
    chk("len_pre", 64'(len_err), 64'd0);
    push(32'd14, 1'b0);
    tick();
    chk("len_miss", 64'(len_err), 64'd1);
    push(32'd15, 1'b1);
    tick();
    chk("len_sticky", 64'(len_err), 64'd1);
    do_clr();
    chk("clr2_len_err", 64'(len_err), 64'd0);

    // zero length flags on any pop
    data_length = 32'd0;
    push(32'd7, 1'b0);
    tick();
    chk("len_zero", 64'(len_err), 64'd1);
    do_clr();

    // back-to-back single-sample frames: pop in DONE starts the next frame
    data_length = 32'd1;
    fd0 = fd_cnt;
    push(32'd21, 1'b1);
    push(32'd22, 1'b1);
    tick();
    chk("done_pop_fd", 64'(frame_done), 64'd1);
    chk("done_pop_cnt", 64'(out_count), 64'd1);
    tick();
    chk("done_pop_pulses", 64'(fd_cnt - fd0), 64'd2);
    chk("done_pop_len", 64'(len_err), 64'd0);
    do_clr();

    // pointer wrap with random backpressure
    data_length = 32'd1000;
    wrap_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) push($urandom, 1'($urandom_range(0, 1)));
        wrap_run = 1'b0;
      end
      begin
        while (wrap_run) begin
          tick();
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    do_clr();

    // reset mid-frame with 5 buffered entries
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'(200 + i), 1'b0);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk("mid_level", 64'(level), 64'd5);
    fd0 = fd_cnt;
    axis_rst_n = 1'b0;
    tick();
    axis_rst_n = 1'b1;
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_count", 64'(out_count), 64'd0);
    chk("mid_rst_fd", 64'(frame_done), 64'd0);
    tick();
    tick();
    tick();
    chk("mid_rst_no_fd", 64'(fd_cnt - fd0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
